// File: rtl/i8_bit_mul_if.sv
// Operand/result bundle for the 8x8 unsigned multiplier.
// Contract: in_valid qualifies a/b on the edge they are captured; out_valid qualifies prod; no ready, never stalls.
interface i8_bit_mul_if;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic [15:0] prod;

  modport master (
    output in_valid,
    output a,
    output b,
    input  out_valid,
    input  prod
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output out_valid,
    output prod
  );
endinterface

// File: rtl/i8_bit_mul.sv
// Two-stage unsigned 8x8 multiplier: operand capture, then partial-product
// array reduced by a carry-save tree and a final carry-propagate add.
module i8_bit_mul (
  input  logic       clk,
  input  logic       rst,
  i8_bit_mul_if.slave bus
);

  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_v1;
  logic [15:0] r_prod;
  logic        r_out_valid;

  logic [15:0] w_pp [8];
  logic [15:0] w_s0, w_c0, w_s1, w_c1;
  logic [15:0] w_s2, w_c2, w_s3, w_c3;
  logic [15:0] w_s4, w_c4, w_s5, w_c5;
  logic [15:0] w_sum;

  // Row-wide 3:2 compressor; carries leaving bit 15 are dropped because the
  // true product always fits in 16 bits.
  function automatic logic [15:0] csa_sum(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_carry(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z);
    logic [15:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[14:0], 1'b0};
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_pp[i] = r_b[i] ? (16'(r_a) << i) : 16'h0000;
    end
  end

  // 8 rows -> 6 -> 4 -> 3 -> 2
  assign w_s0 = csa_sum  (w_pp[0], w_pp[1], w_pp[2]);
  assign w_c0 = csa_carry(w_pp[0], w_pp[1], w_pp[2]);
  assign w_s1 = csa_sum  (w_pp[3], w_pp[4], w_pp[5]);
  assign w_c1 = csa_carry(w_pp[3], w_pp[4], w_pp[5]);

  assign w_s2 = csa_sum  (w_s0, w_c0, w_s1);
  assign w_c2 = csa_carry(w_s0, w_c0, w_s1);
  assign w_s3 = csa_sum  (w_c1, w_pp[6], w_pp[7]);
  assign w_c3 = csa_carry(w_c1, w_pp[6], w_pp[7]);

  assign w_s4 = csa_sum  (w_s2, w_c2, w_s3);
  assign w_c4 = csa_carry(w_s2, w_c2, w_s3);

  assign w_s5 = csa_sum  (w_s4, w_c4, w_c3);
  assign w_c5 = csa_carry(w_s4, w_c4, w_c3);

  assign w_sum = w_s5 + w_c5;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_v1        <= 1'b0;
      r_prod      <= 16'h0000;
      r_out_valid <= 1'b0;
    end else begin
      r_a         <= bus.a;
      r_b         <= bus.b;
      r_v1        <= bus.in_valid;
      r_prod      <= w_sum;
      r_out_valid <= r_v1;
    end
  end

  assign bus.prod      = r_prod;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_i8_bit_mul.sv
// Self-checking bench for i8_bit_mul: directed vectors, streaming, validity
// gaps, mid-stream reset and a random sweep against a plain multiply model.
module tb_i8_bit_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // Each entry is {valid, product}; exp_q[0] is what the outputs must show now.
  logic [16:0] exp_q[$];

  i8_bit_mul_if bus ();

  i8_bit_mul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, check outputs.
  task automatic step(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    rst          = r;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_q.push_back(17'h0);
      exp_q.push_back(17'h0);
    end else begin
      p = 16'(a) * 16'(b);
      exp_q.push_back({v, p});
      void'(exp_q.pop_front());
    end
    #1;
    check("prod", 32'(bus.prod), 32'(exp_q[0][15:0]));
    check("out_valid", 32'(bus.out_valid), 32'(exp_q[0][16]));
  endtask

  logic [7:0]  va [8];
  logic [7:0]  vb [8];
  logic [15:0] vp [8];

  initial begin
    va[0] = 8'd12;  vb[0] = 8'd5;   vp[0] = 16'h003C;
    va[1] = 8'd240; vb[1] = 8'd15;  vp[1] = 16'h0E10;
    va[2] = 8'd170; vb[2] = 8'd85;  vp[2] = 16'h3872;
    va[3] = 8'd0;   vb[3] = 8'd201; vp[3] = 16'h0000;
    va[4] = 8'd255; vb[4] = 8'd255; vp[4] = 16'hFE01;
    va[5] = 8'd171; vb[5] = 8'd205; vp[5] = 16'h88EF;
    va[6] = 8'd238; vb[6] = 8'd255; vp[6] = 16'hED12;
    va[7] = 8'd31;  vb[7] = 8'd15;  vp[7] = 16'h01D1;

    bus.in_valid = 1'b0;
    bus.a        = 8'h00;
    bus.b        = 8'h00;

    // Reset held two cycles with all-ones operands, then one idle cycle.
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    check("reset_prod", 32'(bus.prod), 32'h0);
    check("reset_valid", 32'(bus.out_valid), 32'h0);

    // Isolated directed vectors against hand-computed constants.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, va[i], vb[i]);
      step(1'b0, 1'b0, 8'h00, 8'h00);
      check("const_prod", 32'(bus.prod), 32'(vp[i]));
      check("const_valid", 32'(bus.out_valid), 32'h1);
    end
    step(1'b0, 1'b1, 8'd15, 8'd31);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    check("commute", 32'(bus.prod), 32'h01D1);

    // Back-to-back stream of the eight pairs.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, va[i], vb[i]);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);

    // Validity gaps with distinct operands.
    step(1'b0, 1'b1, 8'd7,  8'd9);
    step(1'b0, 1'b0, 8'd13, 8'd11);
    step(1'b0, 1'b1, 8'd200, 8'd3);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset with two operations in flight, then recovery.
    step(1'b0, 1'b1, 8'd99, 8'd77);
    step(1'b0, 1'b1, 8'd250, 8'd251);
    step(1'b1, 1'b1, 8'd44, 8'd55);
    check("midrst_prod", 32'(bus.prod), 32'h0);
    check("midrst_valid", 32'(bus.out_valid), 32'h0);
    step(1'b0, 1'b1, 8'd123, 8'd45);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    check("recover_prod", 32'(bus.prod), 32'(16'd5535));
    step(1'b0, 1'b0, 8'h00, 8'h00);

    // Random sweep with sparse resets and random validity.
    for (int i = 0; i < 1200; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom));
    end
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i8_bit_mul.md
# i8_bit_mul

Unsigned 8×8-bit integer multiplier producing the full 16-bit product. It is a self-contained arithmetic block for the multiplier datapath. Operands are captured on a clock edge, and the product is computed by a structural partial-product array with a carry-save reduction tree. The result appears at a registered output after a fixed two-cycle latency.

## Interface
Parameters: none; all widths are fixed.

- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies a and b in the current cycle
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- out_valid  output  1  prod holds the result of a valid operand pair
- prod  output  16  unsigned product a×b, registered

## Operation
- Arithmetic:
  - prod = a × b, treated as unsigned 8-bit × 8-bit.
  - The result is the full 16-bit product. There is no truncation, saturation or overflow; the maximum is 255×255 = 65025 (0xFE01).
- Stage 1 (capture): registers a, b and in_valid into a_r, b_r and v1.
- Stage 2 (compute):
  - Form 8 partial products pp[i] = (b_r[i] ? a_r : 0) << i.
  - Reduce them with a carry-save tree of full and half adders down to two rows.
  - Add the two rows with a 16-bit final carry-propagate adder.
  - Register the sum into prod and v1 into out_valid.
- The pipeline is free-running:
  - Operands are captured every cycle regardless of in_valid.
  - prod always reflects the a and b sampled two edges earlier.
  - out_valid marks which of those results are meaningful.
- Stalls: there is no backpressure and no stall input, so one operation can be issued per cycle.
- Sign: operand bit 7 is a magnitude bit. There is no signed mode.

## Timing
- Reset:
  - On a rising edge with rst=1, clear a_r, b_r, v1, prod and out_valid to 0.
  - Reset has priority over every other update.
- After reset deasserts, prod is 0 and out_valid is 0 until new operands propagate. The first valid result appears two edges after capture.
- Latency:
  - Operands present at edge N appear on prod after edge N+1.
  - out_valid follows in_valid with the same two-edge delay.
- Throughput: one result per cycle. Back-to-back valid operands produce back-to-back valid results with no bubbles.
- Reset mid-operation:
  - In-flight results are discarded.
  - prod and out_valid are 0 on the cycle after the reset edge.
  - Operands applied in the reset cycle are not captured.
- Combinational paths: none from inputs to outputs. The critical path is the stage-2 reduction plus the final adder, which is register to register.
- Identical consecutive operands: the output holds the same value each cycle. prod never glitches at a register boundary.

## Test plan
- Reset: hold rst for 2 cycles with a=0xFF and b=0xFF applied -> prod=0x0000 and out_valid=0 during reset and on the first cycle after it.
- Basic values, each issued with in_valid=1 and checked two cycles later:
  - 12×5 -> 60 (0x003C)
  - 240×15 -> 3600 (0x0E10)
  - 170×85 -> 14450 (0x3872)
  - 0×any -> 0
- Extremes and operand order:
  - 255×255 -> 65025 (0xFE01)
  - 171×205 -> 35055 (0x88EF)
  - 238×255 -> 60690 (0xED12)
  - 31×15 and 15×31 -> 465 (0x01D1) both ways (commutativity)
- Streaming: issue the 8 pairs above on consecutive cycles -> 8 consecutive correct results with out_valid=1, in order, starting exactly 2 cycles after the first issue.
- Validity gaps: toggle in_valid 1,0,1 with distinct operands -> out_valid shows 1,0,1 delayed by 2 cycles, and prod still equals the product of the operands sampled in each slot.
- Reset mid-stream: assert rst while 2 operations are in flight -> both are dropped, with prod=0 and out_valid=0 after the edge; the next valid pair after release returns the correct product 2 cycles later. Finish with a random sweep of at least 1000 pairs checked against a reference multiply.
